// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the instruction-fetch and data ports.
// An in-order tag FIFO records who owns each accepted transaction so responses can be routed back.
module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              inst_req,
    input  logic [ADDR_WIDTH-1:0]             inst_addr,
    output logic                              inst_addr_ok,
    output logic                              inst_data_ok,
    output logic [DATA_WIDTH-1:0]             inst_rdata,
    input  logic                              inst_cancel,
    input  logic                              data_req,
    input  logic                              data_wr,
    input  logic [1:0]                        data_size,
    input  logic [ADDR_WIDTH-1:0]             data_addr,
    input  logic [DATA_WIDTH/8-1:0]           data_wstrb,
    input  logic [DATA_WIDTH-1:0]             data_wdata,
    output logic                              data_addr_ok,
    output logic                              data_data_ok,
    output logic [DATA_WIDTH-1:0]             data_rdata,
    output logic                              bus_req,
    output logic                              bus_wr,
    output logic [1:0]                        bus_size,
    output logic [ADDR_WIDTH-1:0]             bus_addr,
    output logic [DATA_WIDTH/8-1:0]           bus_wstrb,
    output logic [DATA_WIDTH-1:0]             bus_wdata,
    input  logic                              bus_addr_ok,
    input  logic                              bus_data_ok,
    input  logic [DATA_WIDTH-1:0]             bus_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_count
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic                   owner_data_q, owner_data_d;
    logic                   cancel_q, cancel_d;
    logic                   hold_wr_q, hold_wr_d;
    logic [1:0]             hold_size_q, hold_size_d;
    logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
    logic [SW-1:0]          hold_wstrb_q, hold_wstrb_d;
    logic [DATA_WIDTH-1:0]  hold_wdata_q, hold_wdata_d;
    logic [MAX_OUTSTANDING-1:0] tag_data_q, tag_data_d;
    logic [MAX_OUTSTANDING-1:0] tag_discard_q, tag_discard_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic full, grant_data, accept, push, pop, push_discard, head_discard;

    always_comb begin
        state_d       = state_q;
        owner_data_d  = owner_data_q;
        cancel_d      = cancel_q;
        hold_wr_d     = hold_wr_q;
        hold_size_d   = hold_size_q;
        hold_addr_d   = hold_addr_q;
        hold_wstrb_d  = hold_wstrb_q;
        hold_wdata_d  = hold_wdata_q;
        bus_req       = 1'b0;
        bus_wr        = 1'b0;
        bus_size      = 2'd2;
        bus_addr      = inst_addr;
        bus_wstrb     = '0;
        bus_wdata     = '0;

        full       = (count_q == CW'(MAX_OUTSTANDING));
        grant_data = (state_q == HOLD) ? owner_data_q : data_req;

        if (!reset) begin
            if (state_q == HOLD) begin
                bus_req = 1'b1;
            end else begin
                bus_req = !full && (data_req || inst_req);
            end
        end

        // A held grant drives the fields captured when it first failed to handshake.
        if (state_q == HOLD) begin
            bus_wr    = hold_wr_q;
            bus_size  = hold_size_q;
            bus_addr  = hold_addr_q;
            bus_wstrb = hold_wstrb_q;
            bus_wdata = hold_wdata_q;
        end else if (grant_data) begin
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_addr  = data_addr;
            bus_wstrb = data_wstrb;
            bus_wdata = data_wdata;
        end

        accept       = bus_req && bus_addr_ok;
        push         = accept;
        push_discard = !grant_data && (inst_cancel || (state_q == HOLD && cancel_q));
        data_addr_ok = accept && grant_data;
        inst_addr_ok = accept && !grant_data && !(state_q == HOLD && (cancel_q || inst_cancel));

        case (state_q)
            IDLE: begin
                if (bus_req && !bus_addr_ok) begin
                    state_d      = HOLD;
                    owner_data_d = grant_data;
                    cancel_d     = !grant_data && inst_cancel;
                    hold_wr_d    = bus_wr;
                    hold_size_d  = bus_size;
                    hold_addr_d  = bus_addr;
                    hold_wstrb_d = bus_wstrb;
                    hold_wdata_d = bus_wdata;
                end
            end
            HOLD: begin
                cancel_d = cancel_q || (inst_cancel && !owner_data_q);
                if (bus_addr_ok) begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        pop          = !reset && bus_data_ok && (count_q != '0);
        head_discard = tag_discard_q[rd_ptr_q] || inst_cancel;
        data_data_ok = pop && tag_data_q[rd_ptr_q];
        inst_data_ok = pop && !tag_data_q[rd_ptr_q] && !head_discard;

        // Stale discard bits on empty slots are harmless: a push overwrites them.
        tag_data_d    = tag_data_q;
        tag_discard_d = tag_discard_q | ({MAX_OUTSTANDING{inst_cancel}} & ~tag_data_q);
        if (push) begin
            tag_data_d[wr_ptr_q]    = grant_data;
            tag_discard_d[wr_ptr_q] = push_discard;
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_data_q  <= 1'b0;
            cancel_q      <= 1'b0;
            tag_data_q    <= '0;
            tag_discard_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            owner_data_q  <= owner_data_d;
            cancel_q      <= cancel_d;
            tag_data_q    <= tag_data_d;
            tag_discard_q <= tag_discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        hold_wr_q    <= hold_wr_d;
        hold_size_q  <= hold_size_d;
        hold_addr_q  <= hold_addr_d;
        hold_wstrb_q <= hold_wstrb_d;
        hold_wdata_q <= hold_wdata_d;
    end

    // A response with nothing outstanding breaks the bus protocol.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(bus_data_ok && count_q == '0));
        end
    end

    assign inst_rdata        = bus_rdata;
    assign data_rdata        = bus_rdata;
    assign outstanding_count = count_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference of grants and owner tags.
module tb_sram_bus_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          inst_req, inst_cancel, data_req, data_wr;
    logic [AW-1:0] inst_addr, data_addr;
    logic [1:0]    data_size;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata, bus_rdata;
    logic          bus_addr_ok, bus_data_ok;

    logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DW-1:0] inst_rdata, data_rdata, bus_wdata;
    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [2:0]    outstanding_count;

    sram_bus_arbiter #(.MAX_OUTSTANDING(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .outstanding_count(outstanding_count)
    );

    // Reference: who currently holds the bus, and the in-order list of accepted transactions.
    typedef struct {bit is_data; bit discard;} entry_t;
    entry_t q[$];
    int busy_owner;      // -1 none, 0 inst, 1 data
    bit busy_cancel;
    bit last_inst_acc, last_data_acc;
    int vectors, miscompares;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs mid-cycle, then advance the reference.
    task automatic applyStimulus();
        bit full, exp_req, accept, cgrant, pop, exp_iaok, exp_daok, exp_idok, exp_ddok, new_discard;
        int owner;
        entry_t head, e;
        #3;
        if (reset) begin
            checkOutput("rst_bus_req", bus_req, 0);
            checkOutput("rst_inst_addr_ok", inst_addr_ok, 0);
            checkOutput("rst_data_addr_ok", data_addr_ok, 0);
            checkOutput("rst_inst_data_ok", inst_data_ok, 0);
            checkOutput("rst_data_data_ok", data_data_ok, 0);
            @(posedge clock);
            q.delete();
            busy_owner = -1;
            busy_cancel = 0;
            last_inst_acc = 0;
            last_data_acc = 0;
            #1;
            return;
        end
        full = (q.size() == N);
        owner = -1;
        exp_req = 0;
        if (busy_owner >= 0) begin
            exp_req = 1;
            owner = busy_owner;
        end else if (!full && (data_req || inst_req)) begin
            exp_req = 1;
            owner = data_req ? 1 : 0;
        end
        accept   = exp_req && bus_addr_ok;
        cgrant   = (owner == 0) && (busy_owner == 0) && (busy_cancel || inst_cancel);
        exp_daok = accept && owner == 1;
        exp_iaok = accept && owner == 0 && !cgrant;
        pop      = bus_data_ok && q.size() > 0;
        head     = '{is_data: 0, discard: 0};
        if (pop) head = q[0];
        exp_ddok = pop && head.is_data;
        exp_idok = pop && !head.is_data && !(head.discard || inst_cancel);

        checkOutput("bus_req", bus_req, exp_req);
        if (owner == 1) begin
            checkOutput("bus_addr_data", bus_addr, data_addr);
            checkOutput("bus_wr_data", bus_wr, data_wr);
            checkOutput("bus_size_data", bus_size, data_size);
            checkOutput("bus_wstrb_data", bus_wstrb, data_wstrb);
            checkOutput("bus_wdata_data", bus_wdata, data_wdata);
        end else if (owner == 0) begin
            checkOutput("bus_addr_inst", bus_addr, inst_addr);
            checkOutput("bus_wr_inst", bus_wr, 0);
        end
        checkOutput("inst_addr_ok", inst_addr_ok, exp_iaok);
        checkOutput("data_addr_ok", data_addr_ok, exp_daok);
        checkOutput("inst_data_ok", inst_data_ok, exp_idok);
        checkOutput("data_data_ok", data_data_ok, exp_ddok);
        if (exp_idok) checkOutput("inst_rdata", inst_rdata, bus_rdata);
        if (exp_ddok) checkOutput("data_rdata", data_rdata, bus_rdata);
        checkOutput("outstanding_count", outstanding_count, q.size());

        @(posedge clock);
        if (inst_cancel) begin
            foreach (q[i]) if (!q[i].is_data) q[i].discard = 1;
        end
        if (pop) void'(q.pop_front());
        if (accept) begin
            new_discard = (owner == 0) && (inst_cancel || cgrant);
            e = '{is_data: (owner == 1), discard: new_discard};
            q.push_back(e);
            busy_owner = -1;
            busy_cancel = 0;
        end else if (exp_req) begin
            if (busy_owner < 0) begin
                busy_owner = owner;
                busy_cancel = (owner == 0) && inst_cancel;
            end else begin
                busy_cancel = busy_cancel || ((owner == 0) && inst_cancel);
            end
        end
        last_inst_acc = accept && owner == 0;
        last_data_acc = accept && owner == 1;
        #1;
    endtask

    task automatic quiet();
        inst_req = 0; data_req = 0; inst_cancel = 0;
        bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    task automatic respond(input logic [DW-1:0] value);
        bus_data_ok = 1;
        bus_rdata = value;
        applyStimulus();
        bus_data_ok = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        busy_owner = -1; busy_cancel = 0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wr = 0; data_size = 2'd2;
        data_wstrb = 4'hf; data_wdata = 32'h0; bus_rdata = 32'h0;
        quiet();
        reset = 1;
        inst_req = 1; data_req = 1;
        @(posedge clock); #1;
        applyStimulus();
        applyStimulus();
        reset = 0;
        quiet();
        applyStimulus();

        // Simultaneous requests: data wins, inst follows.
        $display("[TB] priority");
        inst_req = 1; inst_addr = 32'h0000_0200;
        data_req = 1; data_addr = 32'h0000_0100; data_wr = 0; data_size = 2'd2;
        bus_addr_ok = 1;
        applyStimulus();
        data_req = 0;
        applyStimulus();
        quiet();
        respond(32'h1111_1111);
        respond(32'h2222_2222);
        applyStimulus();

        // Held inst grant is not pre-empted by a later data request.
        $display("[TB] hold");
        inst_req = 1; inst_addr = 32'h0000_0300;
        applyStimulus();
        applyStimulus();
        data_req = 1; data_addr = 32'h0000_0400; data_wr = 0;
        applyStimulus();
        bus_addr_ok = 1;
        applyStimulus();
        inst_req = 0;
        applyStimulus();
        quiet();
        respond(32'h3333_3333);
        respond(32'h4444_4444);

        // Fill the tag FIFO, then free one slot.
        $display("[TB] full");
        inst_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h0000_1000 + 32'(i * 4);
            applyStimulus();
        end
        inst_addr = 32'h0000_1010;
        applyStimulus();
        checkOutput("full_count", outstanding_count, 4);
        bus_data_ok = 1; bus_rdata = 32'h5555_0000;
        applyStimulus();
        bus_data_ok = 0;
        checkOutput("after_pop_count", outstanding_count, 3);
        applyStimulus();
        quiet();
        for (int i = 0; i < 4; i++) respond(32'h5555_0001 + 32'(i));

        // Flush drops both outstanding instruction responses but not the data one.
        $display("[TB] cancel outstanding");
        inst_req = 1; inst_addr = 32'h0000_2000; bus_addr_ok = 1;
        applyStimulus();
        inst_addr = 32'h0000_2004;
        applyStimulus();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_2100;
        applyStimulus();
        quiet();
        inst_cancel = 1;
        applyStimulus();
        inst_cancel = 0;
        respond(32'h6666_0000);
        respond(32'h6666_0001);
        respond(32'h6666_0002);
        checkOutput("cancel_drained", outstanding_count, 0);

        // Flush while an inst grant is held on the bus.
        $display("[TB] cancel in hold");
        inst_req = 1; inst_addr = 32'h0000_3000;
        applyStimulus();
        inst_cancel = 1;
        applyStimulus();
        inst_cancel = 0;
        bus_addr_ok = 1;
        applyStimulus();
        quiet();
        respond(32'h7777_7777);

        // Store field muxing, then reset with transactions outstanding.
        $display("[TB] store and reset");
        data_req = 1; data_wr = 1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = 32'h8000_0004; data_wdata = 32'hdead_beef; bus_addr_ok = 1;
        applyStimulus();
        quiet();
        data_wr = 0;
        respond(32'h0);
        inst_req = 1; bus_addr_ok = 1; inst_addr = 32'h0000_4000;
        applyStimulus();
        applyStimulus();
        quiet();
        reset = 1;
        applyStimulus();
        reset = 0;
        applyStimulus();
        checkOutput("post_reset_count", outstanding_count, 0);

        // Random traffic honouring the requester handshake rules.
        $display("[TB] random");
        for (int c = 0; c < 400; c++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1;
                inst_addr = $urandom & 32'hffff_fffc;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1;
                data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            inst_cancel = ($urandom_range(0, 15) == 0);
            applyStimulus();
            if (last_inst_acc) inst_req = 0;
            if (last_data_acc) data_req = 0;
        end
        quiet();
        while (q.size() > 0) respond($urandom);
        checkOutput("final_count", outstanding_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
